// File: rtl/int_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// int_redirect_ctrl
//
// Interrupt entry/return controller. It samples the external and timer
// interrupt requests, redirects fetch to the trap vector, and records the
// interrupted PC and cause. When an mret reaches Execute, it redirects fetch
// back to the saved PC. After a return, new interrupts are held off for
// HOLDOFF cycles so that the handler's caller can make forward progress.
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst         synchronous, active-low reset
//   ext_irq     external interrupt request (level)
//   timer_irq   timer interrupt request (level)
//   mie         global interrupt enable from the CSR file
//   mtvec       trap vector base; bits [1:0] are ignored
//   PCF         current fetch-stage PC
//   StallD      decode stall from the hazard unit
//   mret_E      mret instruction valid in Execute
//   Int_flush   one-cycle flush of the IF/ID register
//   PCInt       PC presented to the IF/ID register and the fetch mux
//   mepc        saved return PC
//   mcause      saved cause
//   in_handler  high while a handler is executing
// -----------------------------------------------------------------------------
module int_redirect_ctrl #(
   parameter int              XLEN      = 32,
   parameter int              HOLDOFF   = 2,             // 1..15
   parameter logic [XLEN-1:0] CAUSE_EXT = 32'h8000000B,
   parameter logic [XLEN-1:0] CAUSE_TMR = 32'h80000007
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ext_irq,
   input  logic            timer_irq,
   input  logic            mie,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] PCF,
   input  logic            StallD,
   input  logic            mret_E,
   output logic            Int_flush,
   output logic [XLEN-1:0] PCInt,
   output logic [XLEN-1:0] mepc,
   output logic [XLEN-1:0] mcause,
   output logic            in_handler
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_TAKE    = 3'd1;
   localparam logic [2:0] S_HANDLER = 3'd2;
   localparam logic [2:0] S_RET     = 3'd3;
   localparam logic [2:0] S_HOLD    = 3'd4;

   logic [2:0]      state;
   logic [2:0]      state_nxt;
   logic [XLEN-1:0] cause_q;    // cause chosen in IDLE, committed to mcause on TAKE exit
   logic [3:0]      hold_cnt;
   logic            take;

   // Requests are only honoured when decode can accept the flush.
   assign take = (ext_irq | timer_irq) & mie & ~StallD;

   // NOTE: every signal assigned in a combinational block gets a default
   // first, so that no path leaves it unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (take) state_nxt = S_TAKE;
         S_TAKE:    state_nxt = S_HANDLER;
         S_HANDLER: if (mret_E) state_nxt = S_RET;
         S_RET:     state_nxt = S_HOLD;
         // Exit on the count of one so HOLD lasts exactly HOLDOFF cycles.
         S_HOLD:    if (hold_cnt <= 4'd1) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so that every
   // register samples the values from before the clock edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         cause_q    <= '0;
         hold_cnt   <= '0;
         mepc       <= '0;
         mcause     <= '0;
         in_handler <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               // External wins when both requests are present.
               if (take) cause_q <= ext_irq ? CAUSE_EXT : CAUSE_TMR;
            end
            S_TAKE: begin
               mepc       <= PCF;
               mcause     <= cause_q;
               in_handler <= 1'b1;
            end
            S_RET: begin
               in_handler <= 1'b0;
               hold_cnt   <= 4'(HOLDOFF);
            end
            S_HOLD: begin
               hold_cnt <= hold_cnt - 4'd1;
            end
            default: ;
         endcase
      end
   end

   // Only TAKE and RET override the fetch PC; otherwise it passes through.
   always_comb begin
      Int_flush = 1'b0;
      PCInt     = PCF;
      case (state)
         S_TAKE: begin
            Int_flush = 1'b1;
            PCInt     = {mtvec[XLEN-1:2], 2'b00};
         end
         S_RET: begin
            Int_flush = 1'b1;
            PCInt     = mepc;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_int_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_redirect_ctrl
//
// Bench for int_redirect_ctrl. Each scenario task drives inputs once per
// cycle, shortly after the rising edge, and pushes the outputs it expects for
// that cycle onto a scoreboard. A monitor pops and compares on the falling
// edge. Expected mepc, mcause and in_handler come from model variables that
// the scenario tasks update at the cycle where the DUT should change them.
// -----------------------------------------------------------------------------
module tb_int_redirect_ctrl;

   localparam int XLEN    = 32;
   localparam int HOLDOFF = 2;
   localparam logic [31:0] C_EXT = 32'h8000000B;
   localparam logic [31:0] C_TMR = 32'h80000007;

   logic            clk = 1'b0;
   logic            rst;
   logic            ext_irq;
   logic            timer_irq;
   logic            mie;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] PCF;
   logic            StallD;
   logic            mret_E;
   logic            Int_flush;
   logic [XLEN-1:0] PCInt;
   logic [XLEN-1:0] mepc;
   logic [XLEN-1:0] mcause;
   logic            in_handler;

   int_redirect_ctrl #(
      .XLEN     (XLEN),
      .HOLDOFF  (HOLDOFF),
      .CAUSE_EXT(C_EXT),
      .CAUSE_TMR(C_TMR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ext_irq   (ext_irq),
      .timer_irq (timer_irq),
      .mie       (mie),
      .mtvec     (mtvec),
      .PCF       (PCF),
      .StallD    (StallD),
      .mret_E    (mret_E),
      .Int_flush (Int_flush),
      .PCInt     (PCInt),
      .mepc      (mepc),
      .mcause    (mcause),
      .in_handler(in_handler)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        flush;
      logic [31:0] pcint;
      logic [31:0] mepc;
      logic [31:0] mcause;
      logic        in_handler;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Model of the CSR-facing outputs as visible in the current cycle.
   logic [31:0] m_mepc;
   logic [31:0] m_mcause;
   logic        m_inh;

   // Record the expectation for the current cycle, then move to just after
   // the next rising edge.
   task automatic expect_cycle(input string nm, input logic f, input logic [31:0] pc);
      exp_t e;
      e.name       = nm;
      e.flush      = f;
      e.pcint      = pc;
      e.mepc       = m_mepc;
      e.mcause     = m_mcause;
      e.in_handler = m_inh;
      sb.push_back(e);
      @(posedge clk);
      #2;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_checks++;
         if (Int_flush !== e.flush) begin
            n_fail++;
            $display("FAIL %s Int_flush: got %0b expected %0b", e.name, Int_flush, e.flush);
         end
         n_checks++;
         if (PCInt !== e.pcint) begin
            n_fail++;
            $display("FAIL %s PCInt: got 0x%08h expected 0x%08h", e.name, PCInt, e.pcint);
         end
         n_checks++;
         if (mepc !== e.mepc) begin
            n_fail++;
            $display("FAIL %s mepc: got 0x%08h expected 0x%08h", e.name, mepc, e.mepc);
         end
         n_checks++;
         if (mcause !== e.mcause) begin
            n_fail++;
            $display("FAIL %s mcause: got 0x%08h expected 0x%08h", e.name, mcause, e.mcause);
         end
         n_checks++;
         if (in_handler !== e.in_handler) begin
            n_fail++;
            $display("FAIL %s in_handler: got %0b expected %0b", e.name, in_handler, e.in_handler);
         end
      end
   end

   // From a HANDLER cycle: issue mret, check the RET redirect and the holdoff
   // window. StallD and a stray mret during HOLD must have no effect. Returns
   // just after the edge that enters IDLE.
   task automatic do_return(input string tag);
      mret_E = 1'b1;
      PCF    = 32'h0000_0800;
      expect_cycle({tag, "_hdl_mret"}, 1'b0, PCF);
      mret_E = 1'b0;
      StallD = 1'b1;
      PCF    = 32'h0000_0804;
      expect_cycle({tag, "_ret"}, 1'b1, m_mepc);
      m_inh = 1'b0;
      for (int i = 0; i < HOLDOFF; i++) begin
         mret_E = 1'b1;
         PCF    = 32'h0000_0810 + 32'(4 * i);
         expect_cycle({tag, "_hold"}, 1'b0, PCF);
      end
      mret_E = 1'b0;
      StallD = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0; mie = 1'b0;
      mtvec = 32'h0; PCF = 32'h40; StallD = 1'b0; mret_E = 1'b0;
      m_mepc = 32'h0; m_mcause = 32'h0; m_inh = 1'b0;
      @(posedge clk);
      #2;
      expect_cycle("reset_1", 1'b0, 32'h40);
      expect_cycle("reset_2", 1'b0, 32'h40);
      rst = 1'b1;
   endtask

   task automatic test_basic_take();
      mie = 1'b1; mtvec = 32'h103; PCF = 32'h200; ext_irq = 1'b1;
      expect_cycle("take_idle", 1'b0, 32'h200);
      ext_irq = 1'b0;
      expect_cycle("take_flush", 1'b1, 32'h100);
      m_mepc = 32'h200; m_mcause = C_EXT; m_inh = 1'b1;
      PCF = 32'h204;
      expect_cycle("take_handler", 1'b0, 32'h204);
   endtask

   // Starts in HANDLER with mepc=0x200; ext_irq stays high across the return.
   task automatic test_return_holdoff();
      ext_irq = 1'b1; mret_E = 1'b1; PCF = 32'h208;
      expect_cycle("rh_hdl_mret", 1'b0, 32'h208);
      mret_E = 1'b0; PCF = 32'h20C;
      expect_cycle("rh_ret", 1'b1, 32'h200);
      m_inh = 1'b0;
      for (int i = 0; i < HOLDOFF; i++) begin
         PCF = 32'h210 + 32'(4 * i);
         expect_cycle("rh_hold", 1'b0, PCF);
      end
      PCF = 32'h2F0;
      expect_cycle("rh_idle", 1'b0, 32'h2F0);
      PCF = 32'h300;
      expect_cycle("rh_take", 1'b1, 32'h100);
      ext_irq = 1'b0;
      m_mepc = 32'h300; m_mcause = C_EXT; m_inh = 1'b1;
      PCF = 32'h304;
      expect_cycle("rh_handler", 1'b0, 32'h304);
      do_return("rh2");
   endtask

   task automatic priority_case(input string tag, input logic ext, input logic [31:0] cause);
      ext_irq = ext; timer_irq = 1'b1; StallD = 1'b1; PCF = 32'h400;
      for (int i = 0; i < 3; i++) expect_cycle({tag, "_stall"}, 1'b0, 32'h400);
      StallD = 1'b0;
      expect_cycle({tag, "_release"}, 1'b0, 32'h400);
      ext_irq = 1'b0; timer_irq = 1'b0; PCF = 32'h404;
      expect_cycle({tag, "_take"}, 1'b1, 32'h100);
      m_mepc = 32'h404; m_mcause = cause; m_inh = 1'b1;
      PCF = 32'h408;
      expect_cycle({tag, "_handler"}, 1'b0, 32'h408);
      do_return(tag);
   endtask

   task automatic test_priority_stall();
      priority_case("prio_both", 1'b1, C_EXT);
      priority_case("prio_tmr", 1'b0, C_TMR);
   endtask

   task automatic test_masking();
      ext_irq = 1'b1; mie = 1'b0;
      for (int i = 0; i < 10; i++) begin
         PCF = 32'h500 + 32'(4 * i);
         expect_cycle("mask", 1'b0, PCF);
      end
      ext_irq = 1'b0; mie = 1'b1;
   endtask

   task automatic test_reset_mid_handler();
      timer_irq = 1'b1; PCF = 32'h600;
      expect_cycle("rmh_idle", 1'b0, 32'h600);
      timer_irq = 1'b0; PCF = 32'h604;
      expect_cycle("rmh_take", 1'b1, 32'h100);
      m_mepc = 32'h604; m_mcause = C_TMR; m_inh = 1'b1;
      PCF = 32'h608; rst = 1'b0;
      expect_cycle("rmh_handler", 1'b0, 32'h608);
      m_mepc = 32'h0; m_mcause = 32'h0; m_inh = 1'b0;
      rst = 1'b1; mret_E = 1'b1; PCF = 32'h60C;
      expect_cycle("rmh_after_rst", 1'b0, 32'h60C);
      mret_E = 1'b0; PCF = 32'h610;
      expect_cycle("rmh_no_ret", 1'b0, 32'h610);
      PCF = 32'h614;
      expect_cycle("rmh_idle2", 1'b0, 32'h614);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_take();
      test_return_holdoff();
      test_priority_stall();
      test_masking();
      test_reset_mid_handler();
      @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
